// File: rtl/auction_bid_collector.sv
// Bid collector for the sealed-bid auction stage: opens a round on start, gathers one bid per bidder,
// closes when all have bid (or on a deadline when AUCTION_TIMEOUT_EN is defined) and holds the result until bid_ack.
module auction_bid_collector #(
   parameter int N   = 2,
   parameter int W   = 2,
   parameter int T_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_id,
   input  logic [W-1:0]         in_bid,
   output logic                 dup_err,
   output logic [2**N-1:0]      received,
   output logic [(2**N)*W-1:0]  bid,
   output logic                 bid_valid,
   input  logic                 bid_ack,
   output logic                 complete,
   input  logic [T_W-1:0]       timeout_cycles
);

   // state   | meaning
   // IDLE    | waiting for start; last round's bid/received still visible
   // COLLECT | in_ready=1, storing first bid from each bidder
   // DONE    | bid_valid=1, outputs frozen until bid_ack
   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   localparam int B = 2**N;

   state_t         state;
   logic [B-1:0]   id_hot;
   logic           take;
   logic           fresh;
   logic           fills;
   logic           expire;

   always_comb begin
      id_hot        = '0;
      id_hot[in_id] = 1'b1;
      take          = (state == COLLECT) && in_valid;
      fresh         = take && !received[in_id];
      fills         = fresh && (&(received | id_hot));
   end

`ifdef AUCTION_TIMEOUT_EN
   logic [T_W-1:0] deadline;

   assign expire = (state == COLLECT) && (deadline == T_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         deadline <= '0;
      end else if (state == IDLE && start) begin
         deadline <= timeout_cycles;
      end else if (state == COLLECT && deadline != '0) begin
         deadline <= deadline - T_W'(1);
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^timeout_cycles;
   assign expire         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         dup_err   <= 1'b0;
         received  <= '0;
         bid       <= '0;
         bid_valid <= 1'b0;
         complete  <= 1'b0;
      end else begin
         dup_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= COLLECT;
                  in_ready <= 1'b1;
                  bid      <= '0;
                  received <= '0;
               end
            end
            COLLECT: begin
               if (fresh) begin
                  bid[int'(in_id)*W +: W] <= in_bid;
                  received[in_id]         <= 1'b1;
               end
               // duplicates are consumed but dropped: first bid wins
               if (take && received[in_id]) begin
                  dup_err <= 1'b1;
               end
               if (fills || expire) begin
                  state     <= DONE;
                  in_ready  <= 1'b0;
                  bid_valid <= 1'b1;
                  complete  <= fills;
               end
            end
            DONE: begin
               if (bid_ack) begin
                  state     <= IDLE;
                  bid_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               bid_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_auction_bid_collector.sv
// Self-checking bench for auction_bid_collector; timeout scenarios compile in when AUCTION_TIMEOUT_EN is defined.
module tb_auction_bid_collector;

   localparam int N   = 2;
   localparam int W   = 2;
   localparam int T_W = 8;
   localparam int B   = 2**N;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               in_valid;
   logic               in_ready;
   logic [N-1:0]       in_id;
   logic [W-1:0]       in_bid;
   logic               dup_err;
   logic [B-1:0]       received;
   logic [B*W-1:0]     bid;
   logic               bid_valid;
   logic               bid_ack;
   logic               complete;
   logic [T_W-1:0]     timeout_cycles;

   int n_cmp = 0;
   int n_bad = 0;

   logic [B*W-1:0] exp_bid_q[$];
   logic           exp_cpl_q[$];

   always #5 clk = ~clk;

   auction_bid_collector #(.N(N), .W(W), .T_W(T_W)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_id(in_id), .in_bid(in_bid), .dup_err(dup_err), .received(received), .bid(bid),
      .bid_valid(bid_valid), .bid_ack(bid_ack), .complete(complete), .timeout_cycles(timeout_cycles)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic open_round();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // holds in_valid for one edge; caller drops it when the burst ends
   task automatic offer(input int id, input int val);
      in_valid = 1'b1;
      in_id    = N'(id);
      in_bid   = W'(val);
      tick();
   endtask

   task automatic quiet();
      in_valid = 1'b0;
   endtask

   task automatic wait_and_score(input string name);
      logic [B*W-1:0] eb;
      logic           ec;
      int k;
      k = 0;
      while (!bid_valid && k < 50) begin
         tick();
         k++;
      end
      n_cmp++;
      if (bid_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_timeout: bid_valid=%b required 1 within 50 cycles", name, bid_valid);
      end
      if (exp_bid_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_queue: scoreboard empty, got bid=%b", name, bid);
      end else begin
         eb = exp_bid_q.pop_front();
         ec = exp_cpl_q.pop_front();
         n_cmp++;
         if (bid !== eb) begin
            n_bad++;
            $display("FAIL %s_bid: got %b required %b", name, bid, eb);
         end
         n_cmp++;
         if (complete !== ec) begin
            n_bad++;
            $display("FAIL %s_complete: got %b required %b", name, complete, ec);
         end
      end
   endtask

   task automatic ack_round();
      bid_ack = 1'b1;
      tick();
      bid_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({in_ready, dup_err, received, bid, bid_valid, complete} !== '0) begin
         n_bad++;
         $display("FAIL reset: in_ready=%b dup_err=%b received=%b bid=%b bid_valid=%b complete=%b required all 0",
                  in_ready, dup_err, received, bid, bid_valid, complete);
      end
   endtask

   task automatic test_back_to_back();
      logic [B*W-1:0] held;
      open_round();
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_ready: in_ready=%b required 1", in_ready);
      end
      exp_bid_q.push_back(8'b10_11_00_01);
      exp_cpl_q.push_back(1'b1);
      offer(2, 3);
      offer(0, 1);
      offer(3, 2);
      n_cmp++;
      if (bid_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_early: bid_valid=%b required 0 after 3 accepts", bid_valid);
      end
      offer(1, 0);
      quiet();
      n_cmp++;
      if (bid_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_latency: bid_valid=%b in_ready=%b required 1/0", bid_valid, in_ready);
      end
      wait_and_score("b2b");
      held = bid;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (bid !== 8'b10_11_00_01 || bid_valid !== 1'b1 || in_ready !== 1'b0 || received !== 4'b1111) begin
            n_bad++;
            $display("FAIL hold_%0d: bid=%b bid_valid=%b in_ready=%b received=%b required 10110001/1/0/1111",
                     i, bid, bid_valid, in_ready, received);
         end
      end
      ack_round();
      n_cmp++;
      if (bid_valid !== 1'b0 || in_ready !== 1'b0 || bid !== held) begin
         n_bad++;
         $display("FAIL ack_idle: bid_valid=%b in_ready=%b bid=%b required 0/0/%b", bid_valid, in_ready, bid, held);
      end
      open_round();
      n_cmp++;
      if (bid !== '0 || received !== '0) begin
         n_bad++;
         $display("FAIL start_clear: bid=%b received=%b required 0/0", bid, received);
      end
   endtask

   // runs inside the round opened by test_back_to_back
   task automatic test_duplicate();
      offer(1, 2);
      n_cmp++;
      if (dup_err !== 1'b0) begin
         n_bad++;
         $display("FAIL dup_first: dup_err=%b required 0", dup_err);
      end
      offer(1, 3);
      quiet();
      n_cmp++;
      if (dup_err !== 1'b1 || received !== 4'b0010 || bid[3:2] !== 2'd2) begin
         n_bad++;
         $display("FAIL dup_pulse: dup_err=%b received=%b slot1=%0d required 1/0010/2", dup_err, received, bid[3:2]);
      end
      tick();
      n_cmp++;
      if (dup_err !== 1'b0) begin
         n_bad++;
         $display("FAIL dup_width: dup_err=%b required 0 after one cycle", dup_err);
      end
      exp_bid_q.push_back(8'b11_00_10_01);
      exp_cpl_q.push_back(1'b1);
      offer(0, 1);
      offer(2, 0);
      offer(3, 3);
      quiet();
      wait_and_score("dup_round");
      ack_round();
   endtask

   task automatic test_reset_mid();
      int seen;
      open_round();
      offer(0, 3);
      offer(1, 2);
      quiet();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (received !== '0 || bid !== '0 || in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid: received=%b bid=%b in_ready=%b required 0/0/0", received, bid, in_ready);
      end
      seen = 0;
      offer(2, 1);
      offer(3, 1);
      quiet();
      for (int i = 0; i < 8; i++) begin
         if (bid_valid) seen++;
         tick();
      end
      n_cmp++;
      if (seen != 0 || received !== '0) begin
         n_bad++;
         $display("FAIL rst_no_valid: bid_valid cycles=%0d received=%b required 0/0000", seen, received);
      end
   endtask

`ifdef AUCTION_TIMEOUT_EN
   task automatic test_timeout();
      timeout_cycles = 8'd6;
      open_round();
      exp_bid_q.push_back(8'b00_01_00_11);
      exp_cpl_q.push_back(1'b0);
      offer(0, 3);
      offer(2, 1);
      quiet();
      tick(); tick(); tick();
      n_cmp++;
      if (bid_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL to_early: bid_valid=%b required 0 after 5 collect cycles", bid_valid);
      end
      tick();
      n_cmp++;
      if (bid_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL to_expiry: bid_valid=%b required 1 after 6 collect cycles", bid_valid);
      end
      wait_and_score("timeout");
      ack_round();
   endtask

   task automatic test_expiry_win();
      timeout_cycles = 8'd4;
      open_round();
      exp_bid_q.push_back(8'b01_10_11_00);
      exp_cpl_q.push_back(1'b1);
      offer(0, 0);
      offer(1, 3);
      offer(2, 2);
      offer(3, 1);
      quiet();
      wait_and_score("expiry_win");
      ack_round();
   endtask
`endif

   task automatic test_no_deadline();
      int seen;
`ifdef AUCTION_TIMEOUT_EN
      timeout_cycles = 8'd0;
`else
      timeout_cycles = 8'd3;
`endif
      open_round();
      exp_bid_q.push_back(8'b11_11_00_10);
      exp_cpl_q.push_back(1'b1);
      offer(0, 2);
      offer(1, 0);
      offer(2, 3);
      quiet();
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (bid_valid) seen++;
         tick();
      end
      n_cmp++;
      if (seen != 0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL no_deadline: bid_valid cycles=%0d in_ready=%b required 0/1", seen, in_ready);
      end
      offer(3, 3);
      quiet();
      wait_and_score("no_deadline");
      ack_round();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_id = '0; in_bid = '0;
      bid_ack = 1'b0; timeout_cycles = '0;
      test_reset();
      test_back_to_back();
      test_duplicate();
      test_reset_mid();
`ifdef AUCTION_TIMEOUT_EN
      test_timeout();
      test_expiry_win();
`endif
      test_no_deadline();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/auction_bid_collector.md
Name: auction_bid_collector

Overview:
- Sequential front end that feeds the combinational sealed-bid auction stage directly downstream.
- Opens a bidding round and accepts one bid per bidder over a valid/ready handshake.
- Stores bids in a per-bidder register file and closes the round when every bidder has bid, or optionally on a deadline.
- Presents the flattened bid vector, bidder 0 in the LSBs, held stable until the consumer acknowledges it.

Parameters:
N, 2, log2 of bidder count (2**N bidders; bidder ids are N bits)
W, 2, bid value width in bits
T_W, 8, width of the deadline counter and of timeout_cycles

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse that opens a round; honoured only in IDLE
in_valid  input  1  bid offered this cycle
in_ready  output  1  collector accepts a bid this cycle
in_id  input  N  bidder index of the offered bid
in_bid  input  W  offered bid value
dup_err  output  1  one-cycle pulse: an accepted handshake carried an already-received id
received  output  2**N  bit i set once bidder i's bid is stored
bid  output  (2**N)*W  flattened bids; bidder i occupies bits (i+1)*W-1 : i*W
bid_valid  output  1  round closed; bid is stable
bid_ack  input  1  consumer has taken bid; honoured only while bid_valid=1
complete  output  1  meaningful while bid_valid=1; 1 if all bidders bid, 0 if the round was closed by the deadline
timeout_cycles  input  T_W  deadline length in cycles; 0 disables the deadline (used only with the optional feature)

Behaviour:
- Clocking and reset: single clock domain, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, dup_err=0, received=0, bid=0, bid_valid=0, complete=0, deadline counter=0.
- States:
  - IDLE -> COLLECT on start=1. On that edge, all bid slots are cleared to 0 and received is cleared to 0.
  - COLLECT: in_ready=1. A handshake occurs when in_valid=1 and in_ready=1.
  - COLLECT, handshake with received[in_id]=0: store in_bid in slot in_id and set received[in_id] on that edge.
  - COLLECT, handshake with received[in_id]=1: the bid is consumed and dropped; the slot keeps its original value (first bid wins). dup_err is high in the following cycle for exactly 1 cycle.
  - COLLECT -> DONE on the same edge that stores the last missing bid. bid_valid=1 and in_ready=0 from the next cycle. complete=1.
  - DONE: bid, received and complete are held. bid_ack=1 -> IDLE on that edge, and bid_valid drops.
- IDLE outputs: bid and received keep the last round's values; in_ready=0.
- start outside IDLE is ignored. bid_ack outside DONE is ignored.
- Latency: the cycle after the final accepting edge shows bid_valid=1. Minimum round is 2**N accept cycles plus 1.
- rst asserted mid-round aborts the round: all reset values apply on that edge and no bid_valid is produced.
- In COLLECT, in_id and in_bid are used only when in_valid=1.

Optional Feature:
- Macro: AUCTION_TIMEOUT_EN.
- Defined:
  - The start edge loads the counter with timeout_cycles.
  - Each COLLECT cycle decrements the counter while it is nonzero.
  - COLLECT with counter==1 and no completing bid -> DONE on that edge, with complete=0. Missing slots stay 0.
  - A completing bid on the expiry edge wins: DONE with complete=1.
  - timeout_cycles=0 disables the deadline.
- Not defined: the counter logic is absent, timeout_cycles is ignored, and only a full set of bids closes the round. complete is always 1 in DONE.

Test Plan:
- N=2, W=2. start, then bids (id,val) = (2,3), (0,1), (3,2), (1,0) back-to-back -> bid_valid in the cycle after the 4th accept; bid=8'b10_11_00_01; complete=1; in_ready=0 while bid_valid=1.
- Duplicate: (1,2), then (1,3) -> dup_err pulses once one cycle after the second accept; slot 1 stays 2; received=4'b0010.
- Hold until acknowledged: in DONE, keep bid_ack=0 for 5 cycles -> bid and bid_valid stable. Assert bid_ack -> IDLE next cycle; start then clears bid to 0.
- Reset mid-round: rst after 2 accepts -> received=0, bid=0, in_ready=0 next cycle; no bid_valid.
- With AUCTION_TIMEOUT_EN: timeout_cycles=6, bids only for ids 0 (val 3) and 2 (val 1) -> DONE after the 6th COLLECT cycle; complete=0; bid=8'b00_01_00_11.
- With AUCTION_TIMEOUT_EN: last missing bid arrives on the expiry cycle -> complete=1. Separately, timeout_cycles=0 -> the round never closes early.
